// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache's view; the master modport is the view of the
// datapath/memory pair that drives the cache.
interface icache_if #(
    parameter int WORD_W = 32
);
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a COMPARE/FILL
// controller and saturating hit/miss counters.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    localparam int IBLK_W = 0;
    localparam int IBYT_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    // IBLK_W is zero (one word per frame), so the block-offset field is absent.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;
endpackage

// state   | meaning
// COMPARE | look up imemaddr; a miss latches the address and starts a fill
// FILL    | read the latched word from memory until iwait drops, then write it
module icache
    import cpu_types_pkg::*;
#(
    parameter int HITCNT_W = 16
) (
    input  logic                CLK,
    input  logic                RST,
    icache_if.slave             cif,
    output logic [HITCNT_W-1:0] hit_count,
    output logic [HITCNT_W-1:0] miss_count
);
    localparam int NFRAMES = 1 << IIDX_W;

    typedef enum logic {COMPARE, FILL} state_t;

    state_t            state;
    state_t            state_nxt;
    icachef_t          req;
    logic [NFRAMES-1:0] valid_q;
    logic [ITAG_W-1:0] tag_q  [NFRAMES];
    word_t             data_q [NFRAMES];
    logic [ITAG_W-1:0] miss_tag;
    logic [IIDX_W-1:0] miss_idx;
    logic              hit;
    logic              miss_take;
    logic              fill_done;
    logic [IBYT_W-1:0] unused_bytoff;

    assign req           = icachef_t'(cif.imemaddr);
    assign unused_bytoff = req.bytoff;
    assign cif.ihit      = hit;

    // Lookup, next-state and output decode; everything is forced idle while RST
    // is high so a reset in the middle of a fill cannot write a frame.
    always_comb begin
        state_nxt    = state;
        hit          = 1'b0;
        miss_take    = 1'b0;
        fill_done    = 1'b0;
        cif.imemload = '0;
        cif.iREN     = 1'b0;
        cif.iaddr    = '0;
        if (!RST) begin
            case (state)
                COMPARE: begin
                    hit = cif.imemREN && valid_q[req.idx] && (tag_q[req.idx] == req.tag);
                    if (hit) begin
                        cif.imemload = data_q[req.idx];
                    end else if (cif.imemREN) begin
                        miss_take = 1'b1;
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    cif.iREN  = 1'b1;
                    cif.iaddr = {miss_tag, miss_idx, {IBYT_W{1'b0}}};
                    if (!cif.iwait) begin
                        fill_done = 1'b1;
                        state_nxt = COMPARE;
                    end
                end
                default: state_nxt = COMPARE;
            endcase
        end
    end

    // Controller state, valid bits, miss address and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= COMPARE;
            valid_q    <= '0;
            miss_tag   <= '0;
            miss_idx   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            if (miss_take) begin
                miss_tag <= req.tag;
                miss_idx <= req.idx;
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
            if (hit && hit_count != '1) begin
                hit_count <= hit_count + 1'b1;
            end
            if (fill_done) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Frame tag and data need no reset; the valid bit guards them.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= cif.iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a frame-array reference model, plus a
// narrow-counter instance for saturation.
module tb_icache;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    icache_if dp ();
    icache_if dp2 ();

    logic [15:0] hc, mc;
    logic [3:0]  hc2, mc2;

    icache u_dut (
        .CLK        (clk),
        .RST        (rst),
        .cif        (dp),
        .hit_count  (hc),
        .miss_count (mc)
    );

    icache #(.HITCNT_W(4)) u_sat (
        .CLK        (clk),
        .RST        (rst),
        .cif        (dp2),
        .hit_count  (hc2),
        .miss_count (mc2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          ref_valid [16];
    logic [25:0] ref_tag   [16];
    logic [31:0] ref_data  [16];
    int          ref_hits;
    int          ref_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic model_fill(input logic [31:0] addr, input logic [31:0] data);
        ref_valid[addr[5:2]] = 1'b1;
        ref_tag[addr[5:2]]   = addr[31:6];
        ref_data[addr[5:2]]  = data;
    endtask

    function automatic bit model_hit(input logic [31:0] addr);
        return ref_valid[addr[5:2]] && (ref_tag[addr[5:2]] == addr[31:6]);
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_hits"}, 32'(hc), sat(ref_hits, 65535));
        check({tag, "_misses"}, 32'(mc), sat(ref_misses, 65535));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dp.imemREN  = 1'b1;
        dp.imemaddr = 32'h40;
        dp.iwait    = 1'b1;
        dp.iload    = '0;
        @(negedge clk);
        check("rst_ihit", 32'(dp.ihit), 0);
        check("rst_imemload", dp.imemload, 0);
        check("rst_iren", 32'(dp.iREN), 0);
        check("rst_iaddr", dp.iaddr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dp.imemREN = 1'b0;
        model_reset();
        check_counts("rst");
    endtask

    // One fetch as the datapath sees it: hold the address until ihit.
    task automatic fetch(input logic [31:0] addr, input int waits, input logic [31:0] data);
        logic [31:0] line;
        line = {addr[31:2], 2'b00};
        dp.imemREN  = 1'b1;
        dp.imemaddr = addr;
        dp.iwait    = 1'b1;
        @(negedge clk);
        if (model_hit(addr)) begin
            check("hit_ihit", 32'(dp.ihit), 1);
            check("hit_data", dp.imemload, ref_data[addr[5:2]]);
            check("hit_iren", 32'(dp.iREN), 0);
            @(posedge clk); #1;
            ref_hits++;
        end else begin
            check("miss_ihit", 32'(dp.ihit), 0);
            check("miss_imemload", dp.imemload, 0);
            check("miss_iren", 32'(dp.iREN), 0);
            @(posedge clk); #1;
            for (int w = 0; w < waits; w++) begin
                @(negedge clk);
                check("fill_wait_iren", 32'(dp.iREN), 1);
                check("fill_wait_iaddr", dp.iaddr, line);
                check("fill_wait_ihit", 32'(dp.ihit), 0);
                @(posedge clk); #1;
            end
            dp.iwait = 1'b0;
            dp.iload = data;
            @(negedge clk);
            check("fill_iren", 32'(dp.iREN), 1);
            check("fill_iaddr", dp.iaddr, line);
            @(posedge clk); #1;
            dp.iwait = 1'b1;
            dp.iload = $urandom;
            model_fill(addr, data);
            ref_misses++;
            @(negedge clk);
            check("refetch_ihit", 32'(dp.ihit), 1);
            check("refetch_data", dp.imemload, data);
            @(posedge clk); #1;
            ref_hits++;
        end
        check_counts("fetch");
    endtask

    task automatic idle(input int n);
        dp.imemREN = 1'b0;
        for (int i = 0; i < n; i++) begin
            dp.imemaddr = $urandom;
            @(negedge clk);
            check("idle_ihit", 32'(dp.ihit), 0);
            check("idle_iren", 32'(dp.iREN), 0);
            @(posedge clk); #1;
        end
        check_counts("idle");
    endtask

    initial begin
        logic [31:0] d;
        dp2.imemREN  = 1'b0;
        dp2.imemaddr = '0;
        dp2.iwait    = 1'b1;
        dp2.iload    = '0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Cold miss with one memory wait cycle.
        fetch(32'h40, 1, 32'h2001000A);
        check("cold_misses", 32'(mc), 1);
        check("cold_hits", 32'(hc), 1);

        // Byte-offset alias, then idle.
        fetch(32'h43, 0, 32'h0);
        idle(10);

        // Conflict eviction in frame 0.
        fetch(32'h440, 0, 32'h0BADF00D);
        fetch(32'h40, 2, 32'h2001000A);
        check("conflict_misses", 32'(mc), 3);

        // Address change while the fill is outstanding.
        d = 32'hCAFE0080;
        dp.imemREN  = 1'b1;
        dp.imemaddr = 32'h80;
        dp.iwait    = 1'b1;
        @(negedge clk);
        check("chg_miss_ihit", 32'(dp.ihit), 0);
        @(posedge clk); #1;
        dp.imemaddr = 32'h84;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("chg_iaddr", dp.iaddr, 32'h80);
            check("chg_iren", 32'(dp.iREN), 1);
            @(posedge clk); #1;
        end
        dp.iwait = 1'b0;
        dp.iload = d;
        @(negedge clk);
        check("chg_iaddr_last", dp.iaddr, 32'h80);
        @(posedge clk); #1;
        dp.iwait = 1'b1;
        model_fill(32'h80, d);
        ref_misses++;
        fetch(32'h84, 1, 32'h12340084);
        fetch(32'h80, 0, 32'h0);

        // Reset while a fill is waiting on memory.
        dp.imemREN  = 1'b1;
        dp.imemaddr = 32'h100;
        dp.iwait    = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rfill_iren", 32'(dp.iREN), 1);
        check("rfill_iaddr", dp.iaddr, 32'h100);
        rst = 1'b1;
        @(negedge clk);
        check("rfill_rst_iren", 32'(dp.iREN), 0);
        check("rfill_rst_iaddr", dp.iaddr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dp.imemREN = 1'b0;
        dp.iwait   = 1'b0;
        dp.iload   = 32'hDEADBEEF;
        model_reset();
        @(negedge clk);
        check("rfill_after_iren", 32'(dp.iREN), 0);
        check("rfill_after_iaddr", dp.iaddr, 0);
        @(posedge clk); #1;
        dp.iwait = 1'b1;
        check_counts("rfill");
        fetch(32'h100, 0, 32'h55550100);
        check("rfill_misses", 32'(mc), 1);
        fetch(32'h40, 0, 32'h66660040);
        fetch(32'h80, 1, 32'h77770080);

        // Randomized fetches over a small address pool to force hits and conflicts.
        for (int n = 0; n < 80; n++) begin
            logic [25:0] t;
            logic [3:0]  x;
            logic [1:0]  b;
            t = 26'($urandom_range(0, 3));
            x = 4'($urandom_range(0, 7));
            b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            fetch({t, x, b}, $urandom_range(0, 3), $urandom);
        end

        // Saturation on the 4-bit counter instance.
        dp2.imemREN  = 1'b1;
        dp2.imemaddr = 32'h40;
        dp2.iwait    = 1'b0;
        dp2.iload    = 32'h00001234;
        @(negedge clk);
        check("sat_miss_ihit", 32'(dp2.ihit), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sat_fill_iren", 32'(dp2.iREN), 1);
        @(posedge clk); #1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("sat_ihit", 32'(dp2.ihit), 1);
            @(posedge clk); #1;
            check("sat_hits", 32'(hc2), sat(i, 15));
        end
        check("sat_misses", 32'(mc2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter HITCNT_W, default 16, width of the saturating hit and miss counters.
REQ-002: The geometry SHALL come from cpu_types_pkg (icachef_t): tag = ITAG_W (26), index = IIDX_W (4, so 16 frames), block = IBLK_W (0, one word per frame), byte offset = IBYT_W (2).
REQ-003: CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004: RST  input  1  synchronous, active-high reset.
REQ-005: imemREN  input  1  datapath fetch request.
REQ-006: imemaddr  input  WORD_W  fetch address, interpreted as icachef_t.
REQ-007: ihit  output  1  imemload is valid for imemaddr this cycle.
REQ-008: imemload  output  WORD_W  instruction word.
REQ-009: iREN  output  1  memory read request.
REQ-010: iaddr  output  WORD_W  memory read address, word-aligned.
REQ-011: iwait  input  1  memory busy; low means iload is valid this cycle.
REQ-012: iload  input  WORD_W  memory read data.
REQ-013: hit_count  output  HITCNT_W  number of hits counted.
REQ-014: miss_count  output  HITCNT_W  number of misses counted.

Function
REQ-015: Storage SHALL be 16 frames, each holding {valid, tag[25:0], data word_t}, and SHALL be indexed by imemaddr.idx.
REQ-016: The FSM SHALL have two states, COMPARE and FILL; the reset state SHALL be COMPARE.
REQ-017: In COMPARE, ihit SHALL be driven combinationally (same cycle): imemREN & frame.valid & (frame.tag == imemaddr.tag).
REQ-018: On a hit, imemload SHALL be frame.data; when ihit=0, imemload SHALL be 0.
REQ-019: In COMPARE with imemREN=1 and no hit: latch {tag, idx} into the miss register and move to FILL on the next edge; ihit=0 in that cycle.
REQ-020: In COMPARE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-021: In FILL, iREN SHALL be 1 and iaddr SHALL be {latched tag, latched idx, 2'b00}; ihit SHALL be 0.
REQ-022: In FILL with iwait=0: write {valid=1, latched tag, iload} into the latched frame and return to COMPARE on the same edge.
REQ-023: As a result, the refetched address hits in the first COMPARE cycle after the fill; minimum miss penalty is 2 cycles plus memory wait cycles.
REQ-024: In FILL with iwait=1: hold state; iaddr SHALL stay stable.
REQ-025: Once FILL is entered, it SHALL complete even if imemaddr changes or imemREN drops; the filled frame SHALL use the latched address, not the live one.
REQ-026: A fill SHALL replace the frame unconditionally (direct-mapped; no dirty state, no writeback).
REQ-027: hit_count SHALL increment on each COMPARE cycle with ihit=1.
REQ-028: miss_count SHALL increment on each COMPARE→FILL transition.
REQ-029: Both counters SHALL saturate at all-ones and not wrap.
REQ-030: imemREN=0 in COMPARE SHALL leave state and counters unchanged, with ihit=0.
REQ-031: Byte-offset bits imemaddr[1:0] SHALL be ignored for compare and fill.

Reset
REQ-032: RST=1 at an edge SHALL clear every valid bit, both counters, and the miss register, and force state COMPARE; this applies from any state, including mid-FILL.
REQ-033: Frame tag and data SHALL need no reset.
REQ-034: During and after reset, outputs SHALL be ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-035: A memory response arriving the cycle after a mid-FILL reset SHALL be ignored, and no frame SHALL be written.

Verification
REQ-036: Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=0 on the second FILL cycle, iload=0x2001000A. Required: iREN=1 with iaddr=0x40 for 2 cycles; the next COMPARE cycle gives ihit=1 and imemload=0x2001000A; miss_count=1, hit_count=1 after that cycle.
REQ-037: Conflict eviction: fill 0x40, then fetch 0x440 (same idx 0, different tag). Required: miss and refill of frame 0; a refetch of 0x40 misses again; miss_count=3.
REQ-038: Address change mid-FILL: miss on 0x80; during FILL (iwait=1 for 3 cycles) imemaddr changes to 0x84. Required: iaddr stays 0x80, frame 0 gets tag(0x80), and 0x84 then misses on its own.
REQ-039: Reset mid-FILL: miss on 0x100, assert RST for 1 cycle while iwait=1, then iwait=0. Required: iREN=0 after reset, no valid frames, and 0x100 misses again (miss_count restarts at 1).
REQ-040: Byte-offset alias and idle: after 0x40 is filled, fetch 0x43. Required: hit with the same data. imemREN=0 for 10 cycles. Required: counters unchanged.
REQ-041: Counter saturation: with HITCNT_W=4, hold a hitting address for 20 cycles. Required: hit_count=15 and it stays at 15.
